mssv_digit_serializer: RTL and testbench
========================================

// Module: mssv_digit_serializer
// PURPOSE
//   Streams a packed student-ID (MSSV) word to the downstream sequence-detector FSM.
//   Emits one DIGIT_W-bit digit per step, most-significant digit first.
//   Sits directly upstream of the detector and drives its mssv digit input.
//   Framing strobes (first/last/done) let the detector's result be sampled per frame.
// PARAMETERS
//   NUM_DIGITS  8       digits per frame (>=2)
//   DIGIT_W     3       bits per digit
//   GAP_CYCLES  0       idle cycles inserted between consecutive digits (0 = back-to-back)
//   IDLE_DIGIT  3'b111  value driven on digit_out whenever digit_valid=0
// PORTS
//   clk          in   1                    clock, rising edge
//   rst          in   1                    reset, asynchronous, active-high
//   start        in   1                    frame request; sampled only in IDLE or DONE
//   abort        in   1                    cancel current frame (synchronous)
//   id_in        in   NUM_DIGITS*DIGIT_W   packed ID; digit 0 = id_in[MSB -: DIGIT_W]
//   digit_out    out  DIGIT_W              current digit, registered
//   digit_valid  out  1                    digit_out carries a frame digit this cycle
//   first        out  1                    high with digit 0
//   last         out  1                    high with digit NUM_DIGITS-1
//   busy         out  1                    high in SEND and GAP states
//   done         out  1                    one-cycle pulse after the last digit of a completed frame
// BEHAVIOUR
//   - All outputs registered.
//   - Reset values: digit_out=IDLE_DIGIT, all other outputs 0, state=IDLE, counters 0.
//   - States: IDLE, SEND, GAP, DONE.
//   - IDLE: start=1 latches id_in into the shift register; go to SEND.
//     Digit 0 is valid in the cycle right after the sampling edge (latency 1).
//   - SEND: drive the indexed digit with digit_valid=1 for exactly one cycle.
//     - Not last digit, GAP_CYCLES=0: stay in SEND with the next digit.
//     - Not last digit, GAP_CYCLES>0: go to GAP.
//     - Last digit: go to DONE.
//   - GAP: digit_valid=0, digit_out=IDLE_DIGIT for GAP_CYCLES cycles, then SEND with the next digit.
//   - DONE: done=1, busy=0 for one cycle, then IDLE.
//     start=1 in DONE restarts: digit 0 is valid the next cycle and done still pulses this cycle.
//   - start while busy: ignored; no re-latch.
//     id_in changes mid-frame: no effect, because the frame is latched.
//   - abort=1 in SEND or GAP: next cycle IDLE, no done pulse, no last; abort wins over start.
//     abort in IDLE or DONE: no effect on state (the done pulse already in flight completes).
//   - Digit index counter width $clog2(NUM_DIGITS); it wraps to 0 at frame end.
//     Gap counter width $clog2(GAP_CYCLES+1).
//   - rst mid-frame: all outputs return to reset values immediately (asynchronous); the frame is lost.
// CONFIGURATION
//   MSSV_SER_LOOP_EN defined:
//     - Adds input port loop (1 bit).
//     - If loop=1 when the last digit is sent, the next step emits digit 0 again from the latched ID.
//       The ID is not re-sampled, and GAP rules apply between last and first.
//     - done pulses in that same next cycle, coincident with first=1 when GAP_CYCLES=0.
//     - loop=0 or abort ends looping normally.
//   MSSV_SER_LOOP_EN undefined:
//     - No loop port.
//     - Every frame ends through DONE to IDLE as described above.
// TESTING  (NUM_DIGITS=4, DIGIT_W=3 unless noted)
//   1. Assert rst -> digit_out=3'b111, digit_valid/first/last/busy/done=0.
//      Deassert rst, hold start=0 for 5 cycles -> outputs unchanged.
//   2. id_in=12'o0605, start pulse, GAP_CYCLES=0
//      -> digits 0,6,0,5 valid on cycles 1-4; first on cycle 1, last on cycle 4; busy on cycles 1-4; done on cycle 5.
//      Chained into the detector, it yields done code 2'b10 on digit 5.
//   3. start and a new id_in pulsed during cycle 2 of a frame -> stream unchanged (0,6,0,5), single done.
//      start held in the DONE cycle -> next frame digit 0 on the following cycle.
//   4. abort during digit 1 -> next cycle digit_valid=0, busy=0, IDLE; no last, no done.
//      rst asserted mid-frame -> outputs reset asynchronously, without waiting for a clock edge.
//   5. GAP_CYCLES=2 -> valid digits on cycles 1,4,7,10 with digit_out=3'b111 in between; done on cycle 11.
//   6. With MSSV_SER_LOOP_EN, loop=1, id 12'o0605
//      -> continuous 0,6,0,5,0,6,... with done+first together.
//      Dropping loop before a last digit -> that frame ends with a DONE cycle, then IDLE.

Source files
------------

// File: rtl/mssv_digit_serializer.sv
// Streams a latched MSSV word to the sequence detector, MSB digit first.
// Optional frame looping is enabled with `define MSSV_SER_LOOP_EN.
module mssv_digit_serializer #(
    parameter int             NUM_DIGITS = 8,
    parameter int             DIGIT_W    = 3,
    parameter int             GAP_CYCLES = 0,
    parameter logic [DIGIT_W-1:0] IDLE_DIGIT = '1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_start,
    input  logic                          i_abort,
`ifdef MSSV_SER_LOOP_EN
    input  logic                          i_loop,
`endif
    input  logic [NUM_DIGITS*DIGIT_W-1:0] i_id_in,
    output logic [DIGIT_W-1:0]            o_digit_out,
    output logic                          o_digit_valid,
    output logic                          o_first,
    output logic                          o_last,
    output logic                          o_busy,
    output logic                          o_done
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int SW = NUM_DIGITS * DIGIT_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [GW-1:0] GAP_LAST =
        GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    logic [1:0]    r_state;
    logic [SW-1:0] r_shift;
    logic [IW-1:0] r_idx;
    logic [GW-1:0] r_gap;

    logic          w_loop;
    logic [IW-1:0] w_idx_next;
    logic [SW-1:0] w_id_rot;
    logic [SW-1:0] w_shift_rot;

`ifdef MSSV_SER_LOOP_EN
    assign w_loop = i_loop;
`else
    assign w_loop = 1'b0;
`endif

    assign w_idx_next  = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    // Rotating (not shifting) keeps the latched ID intact for looping
    assign w_id_rot    = {i_id_in[SW-DIGIT_W-1:0], i_id_in[SW-1 -: DIGIT_W]};
    assign w_shift_rot = {r_shift[SW-DIGIT_W-1:0], r_shift[SW-1 -: DIGIT_W]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_shift       <= '0;
            r_idx         <= '0;
            r_gap         <= '0;
            o_digit_out   <= IDLE_DIGIT;
            o_digit_valid <= 1'b0;
            o_first       <= 1'b0;
            o_last        <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_shift       <= w_id_rot;
                        r_idx         <= '0;
                        o_digit_out   <= i_id_in[SW-1 -: DIGIT_W];
                        o_digit_valid <= 1'b1;
                        o_first       <= 1'b1;
                        o_last        <= 1'b0;
                        o_busy        <= 1'b1;
                        r_state       <= S_SEND;
                    end else begin
                        o_digit_out   <= IDLE_DIGIT;
                        o_digit_valid <= 1'b0;
                        o_first       <= 1'b0;
                        o_last        <= 1'b0;
                        o_busy        <= 1'b0;
                        r_state       <= S_IDLE;
                    end
                end
                S_SEND: begin
                    if (i_abort) begin
                        r_idx         <= '0;
                        r_gap         <= '0;
                        o_digit_out   <= IDLE_DIGIT;
                        o_digit_valid <= 1'b0;
                        o_first       <= 1'b0;
                        o_last        <= 1'b0;
                        o_busy        <= 1'b0;
                        r_state       <= S_IDLE;
                    end else if (r_idx == IDX_LAST && !w_loop) begin
                        r_idx         <= '0;
                        o_digit_out   <= IDLE_DIGIT;
                        o_digit_valid <= 1'b0;
                        o_first       <= 1'b0;
                        o_last        <= 1'b0;
                        o_busy        <= 1'b0;
                        o_done        <= 1'b1;
                        r_state       <= S_DONE;
                    end else if (GAP_CYCLES == 0) begin
                        r_shift       <= w_shift_rot;
                        r_idx         <= w_idx_next;
                        o_digit_out   <= r_shift[SW-1 -: DIGIT_W];
                        o_digit_valid <= 1'b1;
                        o_first       <= (w_idx_next == '0);
                        o_last        <= (w_idx_next == IDX_LAST);
                        o_busy        <= 1'b1;
                        o_done        <= (r_idx == IDX_LAST);
                        r_state       <= S_SEND;
                    end else begin
                        r_gap         <= '0;
                        o_digit_out   <= IDLE_DIGIT;
                        o_digit_valid <= 1'b0;
                        o_first       <= 1'b0;
                        o_last        <= 1'b0;
                        o_busy        <= 1'b1;
                        o_done        <= (r_idx == IDX_LAST);
                        r_state       <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (i_abort) begin
                        r_idx         <= '0;
                        r_gap         <= '0;
                        o_busy        <= 1'b0;
                        r_state       <= S_IDLE;
                    end else if (r_gap == GAP_LAST) begin
                        r_gap         <= '0;
                        r_shift       <= w_shift_rot;
                        r_idx         <= w_idx_next;
                        o_digit_out   <= r_shift[SW-1 -: DIGIT_W];
                        o_digit_valid <= 1'b1;
                        o_first       <= (w_idx_next == '0);
                        o_last        <= (w_idx_next == IDX_LAST);
                        o_busy        <= 1'b1;
                        r_state       <= S_SEND;
                    end else begin
                        r_gap         <= r_gap + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mssv_digit_serializer.sv
// Scoreboard bench for mssv_digit_serializer: back-to-back and gapped builds.
// Loop checks are compiled when MSSV_SER_LOOP_EN is defined.
module tb_mssv_digit_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        s0, s1, abort;
`ifdef MSSV_SER_LOOP_EN
    logic        loop;
`endif
    logic [11:0] id;

    logic [2:0] d0, d1;
    logic       v0, f0, l0, b0, dn0;
    logic       v1, f1, l1, b1, dn1;

    typedef struct packed {
        logic [2:0] d;
        logic       f;
        logic       l;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_done0 = 0;
    int   base;

    always #5 clk = ~clk;

    mssv_digit_serializer #(
        .NUM_DIGITS(4), .DIGIT_W(3), .GAP_CYCLES(0), .IDLE_DIGIT(3'b111)
    ) u_dut (
        .clk(clk), .rst(rst), .i_start(s0), .i_abort(abort),
`ifdef MSSV_SER_LOOP_EN
        .i_loop(loop),
`endif
        .i_id_in(id), .o_digit_out(d0), .o_digit_valid(v0),
        .o_first(f0), .o_last(l0), .o_busy(b0), .o_done(dn0)
    );

    mssv_digit_serializer #(
        .NUM_DIGITS(4), .DIGIT_W(3), .GAP_CYCLES(2), .IDLE_DIGIT(3'b111)
    ) u_gap (
        .clk(clk), .rst(rst), .i_start(s1), .i_abort(abort),
`ifdef MSSV_SER_LOOP_EN
        .i_loop(1'b0),
`endif
        .i_id_in(id), .o_digit_out(d1), .o_digit_valid(v1),
        .o_first(f1), .o_last(l1), .o_busy(b1), .o_done(dn1)
    );

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push0(input logic [11:0] v, input int nd);
        for (int k = 0; k < nd; k++)
            q0.push_back('{v[11-3*k -: 3], k == 0, k == 3});
    endtask

    task automatic push1(input logic [11:0] v, input int nd);
        for (int k = 0; k < nd; k++)
            q1.push_back('{v[11-3*k -: 3], k == 0, k == 3});
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (v0) begin
            if (q0.size() == 0) chk("u0 extra digit", 1, 0);
            else begin
                e0 = q0.pop_front();
                chk("u0 digit", {29'd0, d0}, {29'd0, e0.d});
                chk("u0 first", {31'd0, f0}, {31'd0, e0.f});
                chk("u0 last", {31'd0, l0}, {31'd0, e0.l});
            end
        end
        if (v1) begin
            if (q1.size() == 0) chk("u1 extra digit", 1, 0);
            else begin
                e1 = q1.pop_front();
                chk("u1 digit", {29'd0, d1}, {29'd0, e1.d});
                chk("u1 first", {31'd0, f1}, {31'd0, e1.f});
                chk("u1 last", {31'd0, l1}, {31'd0, e1.l});
            end
        end
        if (dn0) n_done0++;
    end

    initial begin
        rst = 1'b1; s0 = 0; s1 = 0; abort = 0; id = '0;
`ifdef MSSV_SER_LOOP_EN
        loop = 0;
`endif
        repeat (2) tick;
        chk("rst digit", {29'd0, d0}, 32'h7);
        chk("rst valid", {31'd0, v0}, 0);
        chk("rst first", {31'd0, f0}, 0);
        chk("rst last", {31'd0, l0}, 0);
        chk("rst busy", {31'd0, b0}, 0);
        chk("rst done", {31'd0, dn0}, 0);
        chk("rst gap digit", {29'd0, d1}, 32'h7);
        chk("rst gap busy", {31'd0, b1}, 0);
        rst = 1'b0;
        repeat (5) tick;
        chk("idle digit", {29'd0, d0}, 32'h7);
        chk("idle valid", {31'd0, v0}, 0);
        chk("idle busy", {31'd0, b0}, 0);
        chk("idle done", {31'd0, dn0}, 0);

        id = 12'o0605; push0(id, 4); s0 = 1;
        for (int c = 1; c <= 6; c++) begin
            tick; s0 = 0;
            chk($sformatf("t2 valid c%0d", c), {31'd0, v0}, 32'(c <= 4));
            chk($sformatf("t2 busy c%0d", c), {31'd0, b0}, 32'(c <= 4));
            chk($sformatf("t2 done c%0d", c), {31'd0, dn0}, 32'(c == 5));
        end

        base = n_done0;
        id = 12'o0605; push0(id, 4); s0 = 1;
        for (int c = 1; c <= 5; c++) begin
            tick; s0 = 0;
            if (c == 2) begin s0 = 1; id = 12'o7777; end
        end
        chk("t3 done in DONE", {31'd0, dn0}, 1);
        s0 = 1; id = 12'o1234; push0(id, 4);
        tick; s0 = 0;
        chk("t3 restart valid", {31'd0, v0}, 1);
        chk("t3 restart first", {31'd0, f0}, 1);
        repeat (5) tick;
        chk("t3 done count", 32'(n_done0 - base), 2);

        base = n_done0;
        id = 12'o0605; push0(id, 2); s0 = 1;
        tick; s0 = 0;
        tick; abort = 1;
        tick; abort = 0;
        chk("t4 abort valid", {31'd0, v0}, 0);
        chk("t4 abort busy", {31'd0, b0}, 0);
        chk("t4 abort last", {31'd0, l0}, 0);
        repeat (6) tick;
        chk("t4 abort no done", 32'(n_done0 - base), 0);
        chk("t4 idle valid", {31'd0, v0}, 0);

        id = 12'o0605; push0(id, 2); s0 = 1;
        tick; s0 = 0;
        tick;
        #2 rst = 1'b1;
        #1;
        chk("t4 rst digit", {29'd0, d0}, 32'h7);
        chk("t4 rst valid", {31'd0, v0}, 0);
        chk("t4 rst busy", {31'd0, b0}, 0);
        chk("t4 rst first", {31'd0, f0}, 0);
        tick; rst = 1'b0;
        tick;
        chk("t4 post rst valid", {31'd0, v0}, 0);

        id = 12'o0605; push1(id, 4); s1 = 1;
        for (int c = 1; c <= 12; c++) begin
            logic vexp;
            tick; s1 = 0;
            vexp = (c == 1 || c == 4 || c == 7 || c == 10);
            chk($sformatf("t5 valid c%0d", c), {31'd0, v1}, {31'd0, vexp});
            chk($sformatf("t5 done c%0d", c), {31'd0, dn1}, 32'(c == 11));
            chk($sformatf("t5 busy c%0d", c), {31'd0, b1}, 32'(c <= 10));
            if (!vexp)
                chk($sformatf("t5 idle digit c%0d", c), {29'd0, d1}, 32'h7);
        end

`ifdef MSSV_SER_LOOP_EN
        loop = 1; id = 12'o0605; push0(id, 4); push0(id, 4); s0 = 1;
        for (int c = 1; c <= 10; c++) begin
            tick; s0 = 0;
            if (c == 7) loop = 0;
            chk($sformatf("t6 valid c%0d", c), {31'd0, v0}, 32'(c <= 8));
            chk($sformatf("t6 done c%0d", c), {31'd0, dn0},
                32'(c == 5 || c == 9));
            if (c == 5) chk("t6 first with done", {31'd0, f0}, 1);
            if (c == 10) chk("t6 idle busy", {31'd0, b0}, 0);
        end
`endif

        repeat (2) tick;
        chk("u0 queue empty", 32'(q0.size()), 0);
        chk("u1 queue empty", 32'(q1.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
